traffic_phase_fsm: RTL and testbench
====================================

Name: traffic_phase_fsm

Overview:
- Traffic-light sequencing FSM for a two-road intersection (main road, side road).
- Sits directly downstream of the one-second divider and consumes its single-cycle 1 Hz tick.
- All phase timing is counted in whole seconds (ticks).
- Drives registered lamp outputs for both roads; the side road is served only on demand from a vehicle sensor.

Parameters:
- MAIN_GREEN_SEC, 20, minimum main-road green time in seconds
- SIDE_GREEN_SEC, 10, side-road green time in seconds
- YELLOW_SEC, 3, yellow time in seconds (both roads)
- ALL_RED_SEC, 1, all-red clearance time in seconds
- TIMER_W, 6, phase timer width; every *_SEC must be in 1..2^TIMER_W-1

Ports:
- clk  input  1  system clock, same domain as the divider
- controller_reset  input  1  synchronous, active-high reset
- sec_tick  input  1  one-cycle 1 Hz enable pulse from the divider
- side_sensor  input  1  side-road vehicle present; level, sampled every clk
- main_lamp  output  3  {red,yellow,green} for the main road, one-hot, registered
- side_lamp  output  3  {red,yellow,green} for the side road, one-hot, registered
- phase  output  3  current state encoding (debug)
- side_req_pending  output  1  latched side-road request

Behaviour:
- Clock and reset: one clock, clk. Reset is controller_reset, synchronous and active-high. It wins over every other input in the same cycle.
- Reset values:
  - phase = MAIN_GREEN (3'd0)
  - main_lamp = 3'b001
  - side_lamp = 3'b100
  - timer = 0
  - side_req_pending = 0
- States and encodings:
  - MAIN_GREEN = 0, MAIN_YELLOW = 1, ALL_RED_A = 2
  - SIDE_GREEN = 3, SIDE_YELLOW = 4, ALL_RED_B = 5
  - Codes 6 and 7 are illegal and return to MAIN_GREEN on the next clk.
- Lamps per state:
  - MAIN_GREEN: main green, side red.
  - MAIN_YELLOW: main yellow, side red.
  - ALL_RED_A and ALL_RED_B: both red.
  - SIDE_GREEN: main red, side green.
  - SIDE_YELLOW: main red, side yellow.
  - Lamps are registered and change on the same clk edge as phase. Never two greens, never a lamp word that is not one-hot.
- Timer:
  - Cleared to 0 on every state entry.
  - Increments only on cycles where sec_tick = 1.
  - Saturates at 2^TIMER_W-1 and never wraps.
- Request latch:
  - side_req_pending is set on any clk where side_sensor = 1 and phase != SIDE_GREEN.
  - It is cleared on the clk that enters SIDE_GREEN.
  - A sensor assertion in the same cycle as that entry does not re-set it.
- Effective request: req = side_req_pending | side_sensor, so a same-cycle sensor counts.
- Transitions (all qualified by sec_tick = 1):
  - MAIN_GREEN -> MAIN_YELLOW when timer >= MAIN_GREEN_SEC-1 and req = 1. Otherwise MAIN_GREEN holds indefinitely, with the timer saturating.
  - MAIN_YELLOW -> ALL_RED_A when timer == YELLOW_SEC-1.
  - ALL_RED_A -> SIDE_GREEN when timer == ALL_RED_SEC-1.
  - SIDE_GREEN -> SIDE_YELLOW when timer == SIDE_GREEN_SEC-1. Fixed duration, independent of the sensor.
  - SIDE_YELLOW -> ALL_RED_B when timer == YELLOW_SEC-1.
  - ALL_RED_B -> MAIN_GREEN when timer == ALL_RED_SEC-1.
- Latency: state and lamps update on the clk edge that samples the qualifying sec_tick. A phase of N seconds therefore lasts exactly N ticks.
- Ticks on consecutive cycles are legal: each one counts.
- Reset mid-phase: the next edge goes to MAIN_GREEN with the timer cleared and any pending request dropped.

Optional Feature:
- Macro: PED_WALK_EN.
- When defined:
  - Adds input ped_button (1) and output walk_lamp (1, reset 0).
  - ped_button sets the latch ped_pending under the same rules as side_req_pending, and contributes to req.
  - On SIDE_GREEN entry, ped_pending is copied into walk_active and then cleared.
  - walk_lamp = walk_active during SIDE_GREEN only. It drops on the edge leaving SIDE_GREEN.
- When undefined: the ports and logic are absent and behaviour is exactly as above.

Test Plan:
Bench uses MAIN_GREEN_SEC=4, SIDE_GREEN_SEC=3, YELLOW_SEC=2, ALL_RED_SEC=1, sec_tick every 10 clk.
- Reset, no sensor, 20 ticks -> phase stays 0, main_lamp=001, side_lamp=100 throughout.
- Sensor pulse of 1 clk at tick 1 -> side_req_pending=1, MAIN_YELLOW on tick 4, ALL_RED_A on tick 6, SIDE_GREEN on tick 7 (pending clears), SIDE_YELLOW on tick 10, ALL_RED_B on tick 12, MAIN_GREEN on tick 13.
- Sensor held from tick 10 with no prior request -> MAIN_GREEN exits on tick 10 itself (timer saturated, same-cycle req).
- controller_reset asserted during SIDE_GREEN, coincident with sec_tick -> next edge phase=0, lamps 001/100, timer=0, pending=0.
- Force phase to 6 via hierarchical deposit -> phase=0 on the next clk. Scoreboard checks one-hot lamps and no double green every cycle.
- With PED_WALK_EN, ped_button pulse only -> full cycle served, walk_lamp=1 for exactly 3 ticks of SIDE_GREEN, 0 otherwise.

Source files
------------

// File: rtl/traffic_phase_fsm.sv
// Two-road traffic-light sequencer driven by a 1 Hz tick; side road served on demand.
// Optional pedestrian walk lamp on the side-green phase when PED_WALK_EN is defined.
module traffic_phase_fsm #(
  parameter int unsigned MAIN_GREEN_SEC = 20,
  parameter int unsigned SIDE_GREEN_SEC = 10,
  parameter int unsigned YELLOW_SEC     = 3,
  parameter int unsigned ALL_RED_SEC    = 1,
  parameter int unsigned TIMER_W        = 6
) (
  input  logic       clk,
  input  logic       controller_reset,
  input  logic       sec_tick,
  input  logic       side_sensor,
`ifdef PED_WALK_EN
  input  logic       ped_button,
  output logic       walk_lamp,
`endif
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic [2:0] phase,
  output logic       side_req_pending
);

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
    StAllRedA    = 3'd2,
    StSideGreen  = 3'd3,
    StSideYellow = 3'd4,
    StAllRedB    = 3'd5
  } phase_e;

  localparam logic [TIMER_W-1:0] TimerMax      = '1;
  localparam logic [TIMER_W-1:0] MainGreenLast = TIMER_W'(MAIN_GREEN_SEC - 1);
  localparam logic [TIMER_W-1:0] SideGreenLast = TIMER_W'(SIDE_GREEN_SEC - 1);
  localparam logic [TIMER_W-1:0] YellowLast    = TIMER_W'(YELLOW_SEC - 1);
  localparam logic [TIMER_W-1:0] AllRedLast    = TIMER_W'(ALL_RED_SEC - 1);

  // Kept as raw bits so the illegal codes 6 and 7 stay representable and recoverable.
  logic [2:0]         state_q;
  phase_e             state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pending_d;
  logic [2:0]         main_lamp_d, side_lamp_d;
  logic               req, state_change, entering_sg;

`ifdef PED_WALK_EN
  logic ped_pending_q, ped_pending_d, walk_d;
  assign req = side_req_pending | side_sensor | ped_pending_q | ped_button;
`else
  assign req = side_req_pending | side_sensor;
`endif

  assign phase = state_q;

  always_comb begin
    state_d = StMainGreen;
    case (state_q)
      StMainGreen:  state_d = (sec_tick && req && timer_q >= MainGreenLast) ? StMainYellow
                                                                            : StMainGreen;
      StMainYellow: state_d = (sec_tick && timer_q == YellowLast)    ? StAllRedA    : StMainYellow;
      StAllRedA:    state_d = (sec_tick && timer_q == AllRedLast)    ? StSideGreen  : StAllRedA;
      StSideGreen:  state_d = (sec_tick && timer_q == SideGreenLast) ? StSideYellow : StSideGreen;
      StSideYellow: state_d = (sec_tick && timer_q == YellowLast)    ? StAllRedB    : StSideYellow;
      StAllRedB:    state_d = (sec_tick && timer_q == AllRedLast)    ? StMainGreen  : StAllRedB;
      default:      state_d = StMainGreen;
    endcase
  end

  always_comb begin
    state_change = (state_d != state_q);
    entering_sg  = (state_d == StSideGreen) && (state_q != StSideGreen);

    timer_d = timer_q;
    if (state_change) begin
      timer_d = '0;
    end else if (sec_tick && timer_q != TimerMax) begin
      timer_d = timer_q + 1'b1;
    end

    // Clear on side-green entry wins over a same-cycle sensor.
    pending_d = side_req_pending;
    if (entering_sg) begin
      pending_d = 1'b0;
    end else if (side_sensor && state_q != StSideGreen) begin
      pending_d = 1'b1;
    end

`ifdef PED_WALK_EN
    ped_pending_d = ped_pending_q;
    if (entering_sg) begin
      ped_pending_d = 1'b0;
    end else if (ped_button && state_q != StSideGreen) begin
      ped_pending_d = 1'b1;
    end
    walk_d = 1'b0;
    if (entering_sg) begin
      walk_d = ped_pending_q;
    end else if (state_d == StSideGreen) begin
      walk_d = walk_lamp;
    end
`endif
  end

  // Lamps decode the next state so they change on the same edge as phase.
  always_comb begin
    main_lamp_d = 3'b100;
    side_lamp_d = 3'b100;
    case (state_d)
      StMainGreen:  main_lamp_d = 3'b001;
      StMainYellow: main_lamp_d = 3'b010;
      StSideGreen:  side_lamp_d = 3'b001;
      StSideYellow: side_lamp_d = 3'b010;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (controller_reset) begin
      state_q          <= StMainGreen;
      timer_q          <= '0;
      side_req_pending <= 1'b0;
      main_lamp        <= 3'b001;
      side_lamp        <= 3'b100;
`ifdef PED_WALK_EN
      ped_pending_q    <= 1'b0;
      walk_lamp        <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      side_req_pending <= pending_d;
      main_lamp        <= main_lamp_d;
      side_lamp        <= side_lamp_d;
`ifdef PED_WALK_EN
      ped_pending_q    <= ped_pending_d;
      walk_lamp        <= walk_d;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Self-checking bench for traffic_phase_fsm: directed vector table, hand sequences,
// and randomized stimulus against a per-second phase model. Honours PED_WALK_EN.
module tb_traffic_phase_fsm;

  localparam int MG = 4;
  localparam int SG = 3;
  localparam int YS = 2;
  localparam int AR = 1;
  localparam int TW = 6;

  logic       clk = 1'b0;
  logic       controller_reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       side_sensor = 1'b0;
  logic [2:0] main_lamp, side_lamp, phase;
  logic       side_req_pending;
  logic       ped_sig;
`ifdef PED_WALK_EN
  logic       ped_button = 1'b0;
  logic       walk_lamp;
  assign ped_sig = ped_button;
`else
  assign ped_sig = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b1;

  traffic_phase_fsm #(
    .MAIN_GREEN_SEC(MG),
    .SIDE_GREEN_SEC(SG),
    .YELLOW_SEC    (YS),
    .ALL_RED_SEC   (AR),
    .TIMER_W       (TW)
  ) dut (
    .clk             (clk),
    .controller_reset(controller_reset),
    .sec_tick        (sec_tick),
    .side_sensor     (side_sensor),
`ifdef PED_WALK_EN
    .ped_button      (ped_button),
    .walk_lamp       (walk_lamp),
`endif
    .main_lamp       (main_lamp),
    .side_lamp       (side_lamp),
    .phase           (phase),
    .side_req_pending(side_req_pending)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase index into a duration table, elapsed seconds as a plain integer.
  int dur[6] = '{MG, YS, AR, SG, YS, AR};
  logic [2:0] main_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  typedef struct packed {
    int ph;
    int sec;
    bit pend;
    bit ped;
    bit walk;
    bit ok;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, bit rst, bit tick, bit sens, bit ped);
    mstate_t n;
    bit req, adv;
    n = s;
    if (rst) begin
      n = '0;
      n.ok = 1'b1;
      return n;
    end
    req = s.pend | sens | s.ped | ped;
    adv = 1'b0;
    if (tick) adv = (s.ph == 0) ? (req && (s.sec + 1 >= dur[0])) : (s.sec + 1 == dur[s.ph]);
    if (adv && s.ph == 2) begin
      n.pend = 1'b0;
      n.walk = s.ped;
      n.ped  = 1'b0;
    end else begin
      if (sens && s.ph != 3) n.pend = 1'b1;
      if (ped && s.ph != 3) n.ped = 1'b1;
    end
    if (adv) begin
      n.ph  = (s.ph + 1) % 6;
      n.sec = 0;
      if (s.ph == 3) n.walk = 1'b0;
    end else if (tick) begin
      n.sec = s.sec + 1;
    end
    return n;
  endfunction

  initial begin
    m = '0;
    forever begin
      @(posedge clk);
      m = model_next(m, controller_reset, sec_tick, side_sensor, ped_sig);
    end
  end

  // Per-cycle scoreboard.
  initial forever begin
    @(negedge clk);
    chk("main_onehot", int'($onehot(main_lamp)), 1);
    chk("side_onehot", int'($onehot(side_lamp)), 1);
    chk("double_green", int'(main_lamp[0] & side_lamp[0]), 0);
    if (m.ok && model_on) begin
      chk("sb_phase", phase, m.ph);
      chk("sb_main_lamp", main_lamp, main_tab[m.ph]);
      chk("sb_side_lamp", side_lamp, side_tab[m.ph]);
      chk("sb_pending", side_req_pending, m.pend);
      chk("sb_timer", dut.timer_q, (m.sec > 63) ? 63 : m.sec);
`ifdef PED_WALK_EN
      chk("sb_walk", walk_lamp, m.walk);
`endif
    end
  end

  task automatic apply_reset();
    controller_reset = 1'b1;
    sec_tick = 1'b0;
    side_sensor = 1'b0;
    @(negedge clk);
    controller_reset = 1'b0;
    model_on = 1'b1;
  endtask

  // One second: nine quiet cycles then the tick cycle; returns at the negedge after the tick.
  task automatic do_sec(input bit pulse, input bit level);
    side_sensor = level;
    repeat (9) @(negedge clk);
    sec_tick = 1'b1;
    side_sensor = pulse | level;
    @(negedge clk);
    sec_tick = 1'b0;
    side_sensor = level;
  endtask

  typedef struct packed {
    bit         sens;
    logic [2:0] ph;
    bit         pend;
    logic [2:0] ml;
    logic [2:0] sl;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 1'b1, 3'b001, 3'b100};
    vecs[1]  = '{1'b0, 3'd0, 1'b1, 3'b001, 3'b100};
    vecs[2]  = '{1'b0, 3'd0, 1'b1, 3'b001, 3'b100};
    vecs[3]  = '{1'b0, 3'd1, 1'b1, 3'b010, 3'b100};
    vecs[4]  = '{1'b0, 3'd1, 1'b1, 3'b010, 3'b100};
    vecs[5]  = '{1'b0, 3'd2, 1'b1, 3'b100, 3'b100};
    vecs[6]  = '{1'b0, 3'd3, 1'b0, 3'b100, 3'b001};
    vecs[7]  = '{1'b0, 3'd3, 1'b0, 3'b100, 3'b001};
    vecs[8]  = '{1'b0, 3'd3, 1'b0, 3'b100, 3'b001};
    vecs[9]  = '{1'b0, 3'd4, 1'b0, 3'b100, 3'b010};
    vecs[10] = '{1'b0, 3'd4, 1'b0, 3'b100, 3'b010};
    vecs[11] = '{1'b0, 3'd5, 1'b0, 3'b100, 3'b100};
    vecs[12] = '{1'b0, 3'd0, 1'b0, 3'b001, 3'b100};

    @(negedge clk);
    apply_reset();

    // Reset state and idle main green with no demand.
    chk("rst_phase", phase, 0);
    chk("rst_main_lamp", main_lamp, 3'b001);
    chk("rst_side_lamp", side_lamp, 3'b100);
    chk("rst_timer", dut.timer_q, 0);
    chk("rst_pending", side_req_pending, 0);
    for (int i = 0; i < 20; i++) begin
      do_sec(1'b0, 1'b0);
      chk("idle_phase", phase, 0);
      chk("idle_main_lamp", main_lamp, 3'b001);
      chk("idle_side_lamp", side_lamp, 3'b100);
    end

    // Single-clock sensor pulse on tick 1, full cycle.
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      do_sec(vecs[i].sens, 1'b0);
      chk($sformatf("vec%0d_phase", i + 1), phase, vecs[i].ph);
      chk($sformatf("vec%0d_pending", i + 1), side_req_pending, vecs[i].pend);
      chk($sformatf("vec%0d_main_lamp", i + 1), main_lamp, vecs[i].ml);
      chk($sformatf("vec%0d_side_lamp", i + 1), side_lamp, vecs[i].sl);
    end

    // Sensor first raised on tick 10 with the timer already past the minimum.
    apply_reset();
    for (int i = 0; i < 9; i++) do_sec(1'b0, 1'b0);
    do_sec(1'b0, 1'b1);
    chk("held_exit_phase", phase, 1);
    for (int i = 0; i < 3; i++) do_sec(1'b0, 1'b1);
    chk("held_sg_phase", phase, 3);
    chk("held_sg_pending", side_req_pending, 0);

    // Reset coincident with a tick during side green.
    repeat (9) @(negedge clk);
    controller_reset = 1'b1;
    sec_tick = 1'b1;
    side_sensor = 1'b1;
    @(negedge clk);
    controller_reset = 1'b0;
    sec_tick = 1'b0;
    side_sensor = 1'b0;
    chk("midrst_phase", phase, 0);
    chk("midrst_main_lamp", main_lamp, 3'b001);
    chk("midrst_side_lamp", side_lamp, 3'b100);
    chk("midrst_timer", dut.timer_q, 0);
    chk("midrst_pending", side_req_pending, 0);

    // Illegal state code recovers to main green.
    repeat (3) @(negedge clk);
    model_on = 1'b0;
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    @(negedge clk);
    chk("illegal_phase", phase, 0);
    chk("illegal_main_lamp", main_lamp, 3'b001);
    chk("illegal_side_lamp", side_lamp, 3'b100);
    apply_reset();

`ifdef PED_WALK_EN
    // Pedestrian button only: full cycle, walk lamp lit for the whole side green.
    begin
      int walk_cnt;
      walk_cnt = 0;
      repeat (9) @(negedge clk);
      sec_tick = 1'b1;
      ped_button = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0;
      ped_button = 1'b0;
      for (int c = 0; c < 130; c++) begin
        sec_tick = (c % 10 == 9);
        @(negedge clk);
        sec_tick = 1'b0;
        if (walk_lamp) walk_cnt++;
        chk("walk_vs_sg", walk_lamp, (phase == 3) ? 1 : 0);
      end
      chk("walk_clocks", walk_cnt, 30);
      chk("walk_end_phase", phase, 0);
    end
    apply_reset();
`endif

    // Randomized: dense random ticks, occasional demand and resets.
    for (int c = 0; c < 3000; c++) begin
      sec_tick = ($urandom_range(0, 3) == 0);
      side_sensor = ($urandom_range(0, 15) == 0);
      controller_reset = ($urandom_range(0, 399) == 0);
`ifdef PED_WALK_EN
      ped_button = ($urandom_range(0, 31) == 0);
`endif
      @(negedge clk);
    end
    // Randomized: 1 Hz ticks with sparse demand so main green saturates.
    for (int c = 0; c < 1500; c++) begin
      sec_tick = (c % 10 == 0);
      side_sensor = ($urandom_range(0, 99) == 0);
      controller_reset = 1'b0;
`ifdef PED_WALK_EN
      ped_button = ($urandom_range(0, 199) == 0);
`endif
      @(negedge clk);
    end
    sec_tick = 1'b0;
    side_sensor = 1'b0;
`ifdef PED_WALK_EN
    ped_button = 1'b0;
`endif
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
